// File: rtl/fft_butterfly_ram.sv
// Radix-2 FFT data path: complex sample RAM plus one butterfly per controller read request.
// Optional macro BUTTERFLY_SCALE_EN halves every butterfly output (whole FFT scaled by 1/N).
module fft_butterfly_ram #(
  parameter int L_MAX   = 3,
  parameter int DATA_W  = 16,
  parameter int TW_FRAC = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              initial_flag,
  input  logic              rd_en,
  input  logic [L_MAX-1:0]  rd_add1,
  input  logic [L_MAX-1:0]  rd_add2,
  input  logic [15:0]       factor_re,
  input  logic [15:0]       factor_im,
  input  logic              en_multi,
  input  logic              wr_en,
  input  logic [L_MAX-1:0]  wr_add1,
  input  logic [L_MAX-1:0]  wr_add2,
  output logic              butterfly_finish_flag,
  input  logic              load_en,
  input  logic [L_MAX-1:0]  load_addr,
  input  logic [DATA_W-1:0] load_re,
  input  logic [DATA_W-1:0] load_im,
  input  logic [L_MAX-1:0]  out_addr,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              err_proto
);

  localparam int N      = 1 << L_MAX;
  localparam int PROD_W = 16 + DATA_W + 1;
  localparam int SUM_W  = DATA_W + 2;
  localparam int ROUND  = 1 << (TW_FRAC - 1);

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(1 << (DATA_W - 1)));

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_MULT    = 3'd2;
  localparam logic [2:0] S_SUM     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_WAIT_WR = 3'd5;

  logic [2:0]               state;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [15:0]       w_re, w_im;
  logic signed [SUM_W-1:0]  p_re, p_im;
  logic [DATA_W-1:0]        r1_re, r1_im, r2_re, r2_im;
  logic [DATA_W-1:0]        mem_re [N];
  logic [DATA_W-1:0]        mem_im [N];
  logic signed [PROD_W-1:0] pr_full, pi_full;
  logic signed [SUM_W-1:0]  pr_rnd, pi_rnd;
  logic signed [SUM_W-1:0]  s1_re, s1_im, s2_re, s2_im;
  logic                     wb_fire;

  function automatic logic [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
  endfunction

  assign wb_fire = initial_flag && (state == S_WAIT_WR) && wr_en;

  // Complex product W*B at full width, rounded half-up before dropping the twiddle fraction.
  always_comb begin
    pr_full = PROD_W'(w_re) * PROD_W'(b_re) - PROD_W'(w_im) * PROD_W'(b_im);
    pi_full = PROD_W'(w_re) * PROD_W'(b_im) + PROD_W'(w_im) * PROD_W'(b_re);
    pr_rnd  = SUM_W'((pr_full + PROD_W'(ROUND)) >>> TW_FRAC);
    pi_rnd  = SUM_W'((pi_full + PROD_W'(ROUND)) >>> TW_FRAC);
  end

  always_comb begin
`ifdef BUTTERFLY_SCALE_EN
    s1_re = (SUM_W'(a_re) + p_re) >>> 1;
    s1_im = (SUM_W'(a_im) + p_im) >>> 1;
    s2_re = (SUM_W'(a_re) - p_re) >>> 1;
    s2_im = (SUM_W'(a_im) - p_im) >>> 1;
`else
    s1_re = SUM_W'(a_re) + p_re;
    s1_im = SUM_W'(a_im) + p_im;
    s2_re = SUM_W'(a_re) - p_re;
    s2_im = SUM_W'(a_im) - p_im;
`endif
  end

  // Dropping initial_flag aborts the butterfly from any state without writing back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= S_IDLE;
      butterfly_finish_flag <= 1'b0;
      err_proto             <= 1'b0;
      a_re  <= '0; a_im  <= '0; b_re  <= '0; b_im  <= '0;
      w_re  <= '0; w_im  <= '0; p_re  <= '0; p_im  <= '0;
      r1_re <= '0; r1_im <= '0; r2_re <= '0; r2_im <= '0;
    end else begin
      if (wr_en && state != S_WAIT_WR) err_proto <= 1'b1;
      if (!initial_flag) begin
        state                 <= S_IDLE;
        butterfly_finish_flag <= 1'b0;
      end else begin
        butterfly_finish_flag <= 1'b0;
        case (state)
          S_IDLE: if (rd_en) state <= S_FETCH;
          S_FETCH: begin
            a_re  <= mem_re[rd_add1];
            a_im  <= mem_im[rd_add1];
            b_re  <= mem_re[rd_add2];
            b_im  <= mem_im[rd_add2];
            w_re  <= factor_re;
            w_im  <= factor_im;
            state <= S_MULT;
          end
          S_MULT: if (en_multi) begin
            p_re  <= pr_rnd;
            p_im  <= pi_rnd;
            state <= S_SUM;
          end
          S_SUM: begin
            r1_re <= sat(s1_re);
            r1_im <= sat(s1_im);
            r2_re <= sat(s2_re);
            r2_im <= sat(s2_im);
            butterfly_finish_flag <= 1'b1;
            state <= S_DONE;
          end
          S_DONE:    state <= S_WAIT_WR;
          S_WAIT_WR: if (wr_en) state <= S_IDLE;
          default:   state <= S_IDLE;
        endcase
      end
    end
  end

  // B' is written first so that A' lands last when both targets coincide.
  always_ff @(posedge clk) begin
    if (!initial_flag && load_en) begin
      mem_re[load_addr] <= load_re;
      mem_im[load_addr] <= load_im;
    end
    if (wb_fire) begin
      mem_re[wr_add2] <= r2_re;
      mem_im[wr_add2] <= r2_im;
      mem_re[wr_add1] <= r1_re;
      mem_im[wr_add1] <= r1_im;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_re <= '0;
      out_im <= '0;
    end else begin
      out_re <= mem_re[out_addr];
      out_im <= mem_im[out_addr];
    end
  end

endmodule

// File: tb/tb_fft_butterfly_ram.sv
// Self-checking bench for fft_butterfly_ram: table vectors, protocol corner cases,
// randomized butterflies against a plain-arithmetic model, and full 8-point FFTs.
module tb_fft_butterfly_ram;

  localparam int L_MAX  = 3;
  localparam int DATA_W = 16;
  localparam int N      = 8;

  logic              clk;
  logic              rst;
  logic              initial_flag;
  logic              rd_en;
  logic [L_MAX-1:0]  rd_add1, rd_add2;
  logic [15:0]       factor_re, factor_im;
  logic              en_multi;
  logic              wr_en;
  logic [L_MAX-1:0]  wr_add1, wr_add2;
  logic              butterfly_finish_flag;
  logic              load_en;
  logic [L_MAX-1:0]  load_addr;
  logic [DATA_W-1:0] load_re, load_im;
  logic [L_MAX-1:0]  out_addr;
  logic [DATA_W-1:0] out_re, out_im;
  logic              err_proto;

  int errors = 0;
  int checks = 0;
  int m_re[N];
  int m_im[N];
  int tw_re[4] = '{16384, 11585, 0, -11585};
  int tw_im[4] = '{0, -11585, -16384, -11585};

  typedef struct {
    string name;
    int a_re, a_im, b_re, b_im, w_re, w_im;
    int e1_re, e1_im, e2_re, e2_im;
  } vec_t;

  vec_t vecs[5];

  fft_butterfly_ram #(.L_MAX(L_MAX), .DATA_W(DATA_W), .TW_FRAC(14)) dut (
    .clk(clk), .rst(rst), .initial_flag(initial_flag),
    .rd_en(rd_en), .rd_add1(rd_add1), .rd_add2(rd_add2),
    .factor_re(factor_re), .factor_im(factor_im), .en_multi(en_multi),
    .wr_en(wr_en), .wr_add1(wr_add1), .wr_add2(wr_add2),
    .butterfly_finish_flag(butterfly_finish_flag),
    .load_en(load_en), .load_addr(load_addr), .load_re(load_re), .load_im(load_im),
    .out_addr(out_addr), .out_re(out_re), .out_im(out_im), .err_proto(err_proto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int scaleSat(input longint v);
    longint s;
    s = v;
`ifdef BUTTERFLY_SCALE_EN
    s = s >>> 1;
`endif
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return int'(s);
  endfunction

  // Reference butterfly: A' = A + W*B, B' = A - W*B, W in Q1.14 with round-half-up.
  task automatic modelButterfly(input int ar, ai, br, bi, wr, wi,
                                output int o1r, o1i, o2r, o2i);
    longint pr, pi;
    pr = (longint'(wr) * br - longint'(wi) * bi + 8192) >>> 14;
    pi = (longint'(wr) * bi + longint'(wi) * br + 8192) >>> 14;
    o1r = scaleSat(ar + pr);
    o1i = scaleSat(ai + pi);
    o2r = scaleSat(ar - pr);
    o2i = scaleSat(ai - pi);
  endtask

  task automatic loadSample(input int addr, input int re, input int im);
    initial_flag = 1'b0;
    load_en   = 1'b1;
    load_addr = 3'(addr);
    load_re   = 16'(re);
    load_im   = 16'(im);
    @(posedge clk); #1;
    load_en = 1'b0;
    m_re[addr] = re;
    m_im[addr] = im;
  endtask

  task automatic readOut(input int addr, output int re, output int im);
    out_addr = 3'(addr);
    @(posedge clk); #1;
    re = $signed(out_re);
    im = $signed(out_im);
  endtask

  task automatic checkRam(input string tag, input int addr);
    int re, im;
    readOut(addr, re, im);
    checkOutput($sformatf("%s ram[%0d].re", tag, addr), re, m_re[addr]);
    checkOutput($sformatf("%s ram[%0d].im", tag, addr), im, m_im[addr]);
  endtask

  // Holds rd_en until the finish pulse; returns the cycle index of the pulse (bounded).
  task automatic startAndWait(input int a1, a2, wr, wi, stall, output int cyc);
    initial_flag = 1'b1;
    rd_add1   = 3'(a1);
    rd_add2   = 3'(a2);
    factor_re = 16'(wr);
    factor_im = 16'(wi);
    en_multi  = 1'b0;
    rd_en     = 1'b1;
    cyc = 0;
    while (cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      en_multi = (cyc >= 2 + stall);
      if (butterfly_finish_flag) break;
    end
    rd_en = 1'b0;
  endtask

  task automatic writeBack(input int w1, w2);
    wr_add1 = 3'(w1);
    wr_add2 = 3'(w2);
    wr_en   = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic butterfly(input int a1, a2, w1, w2, wr, wi, stall, input string tag);
    int cyc, o1r, o1i, o2r, o2i;
    modelButterfly(m_re[a1], m_im[a1], m_re[a2], m_im[a2], wr, wi, o1r, o1i, o2r, o2i);
    startAndWait(a1, a2, wr, wi, stall, cyc);
    checkOutput({tag, " latency"}, cyc, 4 + stall);
    @(posedge clk); #1;
    checkOutput({tag, " pulse width"}, int'(butterfly_finish_flag), 0);
    writeBack(w1, w2);
    m_re[w2] = o2r; m_im[w2] = o2i;
    m_re[w1] = o1r; m_im[w1] = o1i;
  endtask

  task automatic applyStimulus(input vec_t v);
    int re, im;
    loadSample(1, v.a_re, v.a_im);
    loadSample(6, v.b_re, v.b_im);
    butterfly(1, 6, 1, 6, v.w_re, v.w_im, 0, v.name);
    readOut(1, re, im);
    checkOutput({v.name, " A'.re"}, re, v.e1_re);
    checkOutput({v.name, " A'.im"}, im, v.e1_im);
    readOut(6, re, im);
    checkOutput({v.name, " B'.re"}, re, v.e2_re);
    checkOutput({v.name, " B'.im"}, im, v.e2_im);
  endtask

  function automatic int bitrev3(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  task automatic runFft(input int x_re[N], input int exp_re[N], input string tag);
    int re, im, half, tw;
    for (int i = 0; i < N; i++) loadSample(bitrev3(i), x_re[i], 0);
    for (int s = 0; s < L_MAX; s++) begin
      half = 1 << s;
      for (int start = 0; start < N; start += 2 * half) begin
        for (int j = 0; j < half; j++) begin
          tw = j * (N / (2 * half));
          butterfly(start + j, start + j + half, start + j, start + j + half,
                    tw_re[tw], tw_im[tw], 0, tag);
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      readOut(k, re, im);
      checkOutput($sformatf("%s bin%0d.re", tag, k), re, exp_re[k]);
      checkOutput($sformatf("%s bin%0d.im", tag, k), im, 0);
    end
  endtask

  initial begin
    int cyc, re, im, a1, a2;
    int x_re[N];
    int e_re[N];

    rst = 1'b1; initial_flag = 1'b0; rd_en = 1'b0; en_multi = 1'b1; wr_en = 1'b0;
    rd_add1 = '0; rd_add2 = '0; factor_re = '0; factor_im = '0;
    wr_add1 = '0; wr_add2 = '0; load_en = 1'b0; load_addr = '0;
    load_re = '0; load_im = '0; out_addr = '0;
    #2 rst = 1'b0;
    #2;
    checkOutput("reset flag", int'(butterfly_finish_flag), 0);
    checkOutput("reset out_re", int'(out_re), 0);
    checkOutput("reset out_im", int'(out_im), 0);
    checkOutput("reset err_proto", int'(err_proto), 0);
    @(posedge clk); #1;
    rst = 1'b1;

`ifdef BUTTERFLY_SCALE_EN
    vecs[0] = '{"w_one",     1000, 0, 200, 0, 16384, 0,      600, 0, 400, 0};
    vecs[1] = '{"w_minus_j", 1000, 0, 200, 0, 0, -16384,     500, -100, 500, 100};
    vecs[2] = '{"sat_pos",   30000, 0, 10000, 0, 16384, 0,   20000, 0, 10000, 0};
    vecs[3] = '{"sat_neg",   -30000, 0, 10000, 0, -16384, 0, -20000, 0, -10000, 0};
    vecs[4] = '{"round",     0, 0, 3, 0, 8192, 0,            1, 0, -1, 0};
`else
    vecs[0] = '{"w_one",     1000, 0, 200, 0, 16384, 0,      1200, 0, 800, 0};
    vecs[1] = '{"w_minus_j", 1000, 0, 200, 0, 0, -16384,     1000, -200, 1000, 200};
    vecs[2] = '{"sat_pos",   30000, 0, 10000, 0, 16384, 0,   32767, 0, 20000, 0};
    vecs[3] = '{"sat_neg",   -30000, 0, 10000, 0, -16384, 0, -32768, 0, -20000, 0};
    vecs[4] = '{"round",     0, 0, 3, 0, 8192, 0,            2, 0, -2, 0};
`endif
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Stray write strobe in IDLE: no RAM change, sticky error.
    for (int i = 0; i < N; i++) loadSample(i, 100 * i + 7, -50 * i - 3);
    initial_flag = 1'b1;
    writeBack(2, 3);
    checkOutput("idle wr err_proto", int'(err_proto), 1);
    checkRam("idle wr", 2);
    checkRam("idle wr", 3);
    repeat (3) @(posedge clk);
    #1 checkOutput("err_proto sticky", int'(err_proto), 1);

    butterfly(0, 5, 0, 5, 11585, -11585, 3, "stall3");
    checkRam("stall3", 0);
    checkRam("stall3", 5);

    // Asynchronous reset while the butterfly sits in MULT.
    initial_flag = 1'b1; rd_add1 = 3'd2; rd_add2 = 3'd3; en_multi = 1'b0; rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    checkOutput("mid-reset flag", int'(butterfly_finish_flag), 0);
    checkOutput("mid-reset err_proto", int'(err_proto), 0);
    @(posedge clk); #1 rst = 1'b1;
    en_multi = 1'b1;
    for (int i = 0; i < N; i++) checkRam("after reset", i);
    butterfly(2, 3, 2, 3, 16384, 0, 0, "post-reset");
    checkRam("post-reset", 2);

    // initial_flag dropped in WAIT_WR: the later strobe must not write.
    startAndWait(4, 7, 0, 16384, 0, cyc);
    checkOutput("abort latency", cyc, 4);
    @(posedge clk); #1 initial_flag = 1'b0;
    @(posedge clk); #1 initial_flag = 1'b1;
    writeBack(4, 7);
    checkRam("abort", 4);
    checkRam("abort", 7);
    checkOutput("abort err_proto", int'(err_proto), 1);

    initial_flag = 1'b1; load_en = 1'b1; load_addr = 3'd5; load_re = 16'd1234; load_im = 16'd99;
    @(posedge clk); #1 load_en = 1'b0;
    checkRam("load while running", 5);

    out_addr = 3'd5; initial_flag = 1'b0; load_en = 1'b1; load_addr = 3'd5;
    load_re = 16'(-777); load_im = 16'd55;
    @(posedge clk); #1 load_en = 1'b0;
    checkOutput("rd-during-wr old", int'($signed(out_re)), m_re[5]);
    m_re[5] = -777; m_im[5] = 55;
    @(posedge clk); #1;
    checkOutput("rd-after-wr new", int'($signed(out_re)), -777);

    butterfly(2, 3, 4, 4, 16384, 0, 0, "same-addr");
    checkRam("same-addr", 4);

    for (int t = 0; t < 20; t++) begin
      a1 = int'($urandom_range(N - 1));
      a2 = (a1 + 1 + int'($urandom_range(N - 2))) % N;
      loadSample(a1, int'($urandom_range(40000)) - 20000, int'($urandom_range(40000)) - 20000);
      loadSample(a2, int'($urandom_range(40000)) - 20000, int'($urandom_range(40000)) - 20000);
      butterfly(a1, a2, a1, a2, int'($urandom_range(32768)) - 16384,
                int'($urandom_range(32768)) - 16384, int'($urandom_range(2)), "rand");
      checkRam("rand", a1);
      checkRam("rand", a2);
    end

    for (int i = 0; i < N; i++) begin
      x_re[i] = (i == 0) ? 1000 : 0;
`ifdef BUTTERFLY_SCALE_EN
      e_re[i] = 125;
`else
      e_re[i] = 1000;
`endif
    end
    runFft(x_re, e_re, "fft impulse");

    for (int i = 0; i < N; i++) begin
      x_re[i] = 100;
`ifdef BUTTERFLY_SCALE_EN
      e_re[i] = (i == 0) ? 100 : 0;
`else
      e_re[i] = (i == 0) ? 800 : 0;
`endif
    end
    runFft(x_re, e_re, "fft const");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
